// File: rtl/if_fetch_queue.sv
// Dual-issue fetch front end: generates fetch PCs, requests instruction word pairs
// from imem, buffers them in a circular queue and presents up to two per cycle.
module if_fetch_queue #(
    parameter int                 D_WIDTH  = 32,
    parameter logic [D_WIDTH-1:0] RESET_PC = '0,
    parameter int                 FQ_DEPTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_Redirect,
    input  logic [D_WIDTH-1:0] i_RedirectPC,
    input  logic               i_Stall,
    output logic               o_ImemReq,
    output logic [D_WIDTH-1:0] o_ImemAddr,
    input  logic [D_WIDTH-1:0] i_ImemRdata1,
    input  logic [D_WIDTH-1:0] i_ImemRdata2,
    output logic [D_WIDTH-1:0] o_PC,
    output logic [D_WIDTH-1:0] o_Instruction1,
    output logic [D_WIDTH-1:0] o_Instruction2,
    output logic               o_Valid1,
    output logic               o_Valid2
);

    localparam int             PW      = $clog2(FQ_DEPTH);
    localparam int             CW      = $clog2(FQ_DEPTH + 1);
    localparam logic [PW:0]    DEPTH_P = (PW + 1)'(FQ_DEPTH);
    localparam logic [CW+1:0]  DEPTH_C = (CW + 2)'(FQ_DEPTH);

    logic [D_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [D_WIDTH-1:0] head_pc_q, head_pc_d;
    logic [CW-1:0]      count_q, count_d;
    logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
    logic               inflight_q, inflight_d;
    logic [D_WIDTH-1:0] mem_q [FQ_DEPTH];

    logic [CW+1:0]      need;
    logic               req;
    logic               push;
    logic [1:0]         pop_n;
    logic [PW-1:0]      rd_ptr_p1;
    logic [PW-1:0]      wr_ptr_p1;
    logic [D_WIDTH-1:0] redirect_pc;

    // Pointer increment with wrap modulo FQ_DEPTH (depth need not be a power of two).
    function automatic logic [PW-1:0] ptr_add(input logic [PW-1:0] p, input logic [1:0] inc);
        logic [PW:0] s;
        s = {1'b0, p} + (PW + 1)'(inc);
        if (s >= DEPTH_P) s = s - DEPTH_P;
        return s[PW-1:0];
    endfunction

    assign redirect_pc = i_RedirectPC & ~D_WIDTH'(3);
    assign rd_ptr_p1   = ptr_add(rd_ptr_q, 2'd1);
    assign wr_ptr_p1   = ptr_add(wr_ptr_q, 2'd1);

    // Admission reserves room for an in-flight pair plus the new pair, ignoring this cycle's pop.
    assign need  = (CW + 2)'(count_q) + (inflight_q ? (CW + 2)'(4) : (CW + 2)'(2));
    assign req   = rst_n & ~i_Redirect & (need <= DEPTH_C);
    assign push  = inflight_q & ~i_Redirect;
    assign pop_n = i_Stall ? 2'd0 : ((count_q >= CW'(2)) ? 2'd2 : count_q[1:0]);

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        head_pc_d  = head_pc_q + D_WIDTH'({pop_n, 2'b00});
        rd_ptr_d   = ptr_add(rd_ptr_q, pop_n);
        wr_ptr_d   = push ? ptr_add(wr_ptr_q, 2'd2) : wr_ptr_q;
        count_d    = count_q + (push ? CW'(2) : CW'(0)) - CW'(pop_n);
        inflight_d = req;
        if (req) fetch_pc_d = fetch_pc_q + D_WIDTH'(8);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_pc_q <= RESET_PC;
            head_pc_q  <= RESET_PC;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            inflight_q <= 1'b0;
        end else if (i_Redirect) begin
            fetch_pc_q <= redirect_pc;
            head_pc_q  <= redirect_pc;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            inflight_q <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            head_pc_q  <= head_pc_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            inflight_q <= inflight_d;
        end
    end

    // Queue storage needs no reset: slots are only visible once counted.
    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            mem_q[wr_ptr_q]  <= i_ImemRdata1;
            mem_q[wr_ptr_p1] <= i_ImemRdata2;
        end
    end

    assign o_ImemReq      = req;
    assign o_ImemAddr     = fetch_pc_q;
    assign o_PC           = head_pc_q;
    assign o_Valid1       = (count_q >= CW'(1));
    assign o_Valid2       = (count_q >= CW'(2));
    assign o_Instruction1 = o_Valid1 ? mem_q[rd_ptr_q]  : '0;
    assign o_Instruction2 = o_Valid2 ? mem_q[rd_ptr_p1] : '0;

endmodule

// File: tb/tb_if_fetch_queue.sv
// Scoreboard bench for if_fetch_queue: imem returns word(a)=a, so every popped
// instruction must equal its expected PC, in order.
module tb_if_fetch_queue;

    localparam int DW = 32;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          redir;
    logic [DW-1:0] redir_pc;
    logic          stall;
    logic          req;
    logic [DW-1:0] addr;
    logic [DW-1:0] rdata1 = '0;
    logic [DW-1:0] rdata2 = '0;
    logic [DW-1:0] pc;
    logic [DW-1:0] ins1, ins2;
    logic          v1, v2;

    int checks = 0;
    int errors = 0;
    int pops   = 0;
    logic [DW-1:0] exp_q[$];

    if_fetch_queue #(.D_WIDTH(DW), .RESET_PC('0), .FQ_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .i_Redirect(redir), .i_RedirectPC(redir_pc),
        .i_Stall(stall), .o_ImemReq(req), .o_ImemAddr(addr),
        .i_ImemRdata1(rdata1), .i_ImemRdata2(rdata2), .o_PC(pc),
        .o_Instruction1(ins1), .o_Instruction2(ins2), .o_Valid1(v1), .o_Valid2(v2)
    );

    always #5 clk = ~clk;

    // imem model: one-cycle read latency, word(a) = a
    always @(posedge clk) begin
        if (req) begin
            rdata1 <= addr;
            rdata2 <= addr + 32'd4;
        end
    end

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic refill(input logic [DW-1:0] start);
        exp_q.delete();
        for (int i = 0; i < 300; i++) exp_q.push_back(start + DW'(4 * i));
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    // Monitor: consumes instructions whenever IF/ID accepts them.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            chk("count_bound", {31'b0, (dut.count_q > 4'(DEPTH))}, 32'd0);
            if (!redir && !stall && v1) begin
                if (exp_q.size() < 2) begin
                    chk("sb_underflow", 32'(exp_q.size()), 32'd2);
                end else begin
                    logic [DW-1:0] e;
                    e = exp_q.pop_front();
                    chk("sb_pc", pc, e);
                    chk("sb_instr1", ins1, e);
                    pops++;
                    if (v2) begin
                        e = exp_q.pop_front();
                        chk("sb_instr2", ins2, e);
                        pops++;
                    end
                end
            end
        end
    end

    initial begin
        int pops_before;
        rst_n = 1'b0; redir = 1'b0; redir_pc = '0; stall = 1'b0;

        @(posedge clk); @(posedge clk); #1;
        @(negedge clk);
        chk("rst_req", {31'b0, req}, 32'd0);
        chk("rst_v1", {31'b0, v1}, 32'd0);
        chk("rst_v2", {31'b0, v2}, 32'd0);
        chk("rst_pc", pc, 32'd0);
        chk("rst_addr", addr, 32'd0);
        chk("rst_ins1", ins1, 32'd0);
        chk("rst_ins2", ins2, 32'd0);
        refill(32'h0);

        // cycle 1: first request
        next_cyc(); rst_n = 1'b1;
        @(negedge clk);
        chk("c1_req", {31'b0, req}, 32'd1);
        chk("c1_addr", addr, 32'h0);
        chk("c1_v1", {31'b0, v1}, 32'd0);
        next_cyc();
        @(negedge clk);
        chk("c2_req", {31'b0, req}, 32'd1);
        chk("c2_addr", addr, 32'h8);
        chk("c2_v1", {31'b0, v1}, 32'd0);

        // cycle 3: first pair visible; stall held from here
        next_cyc(); stall = 1'b1;
        @(negedge clk);
        chk("c3_v1", {31'b0, v1}, 32'd1);
        chk("c3_v2", {31'b0, v2}, 32'd1);
        chk("c3_pc", pc, 32'h0);
        chk("c3_ins1", ins1, 32'h0);
        chk("c3_ins2", ins2, 32'h4);
        next_cyc(); next_cyc(); next_cyc();
        @(negedge clk);
        chk("full_req", {31'b0, req}, 32'd0);
        chk("full_addr", addr, 32'h20);
        chk("full_v2", {31'b0, v2}, 32'd1);
        chk("full_pc", pc, 32'h0);
        next_cyc();
        @(negedge clk);
        chk("full_req2", {31'b0, req}, 32'd0);
        chk("full_count", 32'(dut.count_q), 32'd8);
        next_cyc(); stall = 1'b0;
        repeat (12) next_cyc();

        // redirect to 0x100 with a response in flight
        next_cyc(); redir = 1'b1; redir_pc = 32'h100; refill(32'h100);
        @(negedge clk);
        chk("rd_req", {31'b0, req}, 32'd0);
        next_cyc(); redir = 1'b0;
        @(negedge clk);
        chk("rd1_req", {31'b0, req}, 32'd1);
        chk("rd1_addr", addr, 32'h100);
        chk("rd1_v1", {31'b0, v1}, 32'd0);
        next_cyc();
        @(negedge clk);
        chk("rd2_v1", {31'b0, v1}, 32'd0);
        chk("rd2_addr", addr, 32'h108);
        next_cyc();
        @(negedge clk);
        chk("rd3_pc", pc, 32'h100);
        chk("rd3_ins1", ins1, 32'h100);
        chk("rd3_ins2", ins2, 32'h104);
        repeat (5) next_cyc();

        // redirect to an odd-pair address; low bits are dropped
        next_cyc(); redir = 1'b1; redir_pc = 32'h106; refill(32'h104);
        next_cyc(); redir = 1'b0;
        @(negedge clk);
        chk("ua_addr", addr, 32'h104);
        next_cyc(); next_cyc();
        @(negedge clk);
        chk("ua_pc", pc, 32'h104);
        chk("ua_ins1", ins1, 32'h104);
        chk("ua_ins2", ins2, 32'h108);
        next_cyc();
        @(negedge clk);
        chk("ua_pc2", pc, 32'h10C);
        chk("ua2_ins1", ins1, 32'h10C);
        chk("ua2_ins2", ins2, 32'h110);

        // alternating stall
        pops_before = pops;
        for (int i = 0; i < 50; i++) begin
            next_cyc(); stall = (i % 2 == 0);
        end
        next_cyc(); stall = 1'b0;
        chk("alt_pops_ok", {31'b0, (pops - pops_before >= 40)}, 32'd1);

        // one-cycle reset mid-stream
        next_cyc(); rst_n = 1'b0; refill(32'h0);
        @(negedge clk);
        chk("mr_req", {31'b0, req}, 32'd0);
        next_cyc(); rst_n = 1'b1;
        @(negedge clk);
        chk("mr1_v1", {31'b0, v1}, 32'd0);
        chk("mr1_v2", {31'b0, v2}, 32'd0);
        chk("mr1_pc", pc, 32'h0);
        chk("mr1_ins1", ins1, 32'h0);
        chk("mr1_ins2", ins2, 32'h0);
        chk("mr1_req", {31'b0, req}, 32'd1);
        chk("mr1_addr", addr, 32'h0);
        next_cyc();
        @(negedge clk);
        chk("mr2_v1", {31'b0, v1}, 32'd0);
        next_cyc();
        @(negedge clk);
        chk("mr3_v1", {31'b0, v1}, 32'd1);
        chk("mr3_pc", pc, 32'h0);
        chk("mr3_ins2", ins2, 32'h4);
        repeat (5) next_cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
